// File: rtl/gradient_context_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gradient_context_pipe
// Purpose  : Two-stage JPEG-LS gradient / context stage. Stage 1 registers the
//            local gradients D1=d-b, D2=b-c, D3=c-a; stage 2 quantizes them to
//            -4..+4, sign-merges the vector, forms the context index
//            81*Q_1 + 9*Q_2 + Q_3 and flags run mode.
// Ports    : clk, reset (sync, active-high)
//            in_valid / in_ready, a, b, c, d       - causal neighbour set
//            out_valid / out_ready, Q_1..Q_3, sign,
//            ctx, run_mode                         - quantized context
//            run_count (only with GRAD_RUN_COUNT_EN) - saturating count of
//                                                    run-mode outputs taken
// Options  : GRAD_RUN_COUNT_EN adds the run_count output and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module gradient_context_pipe #(
    parameter int pixel_length = 8,
    parameter int Q_length     = 4,
    parameter int T1           = 3,
    parameter int T2           = 7,
    parameter int T3           = 21,
    parameter int NEAR         = 0,
    parameter int CTX_length   = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [pixel_length-1:0]       a,
    input  logic [pixel_length-1:0]       b,
    input  logic [pixel_length-1:0]       c,
    input  logic [pixel_length-1:0]       d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [Q_length-1:0]    Q_1,
    output logic signed [Q_length-1:0]    Q_2,
    output logic signed [Q_length-1:0]    Q_3,
    output logic                          sign,
    output logic [CTX_length-1:0]         ctx,
`ifdef GRAD_RUN_COUNT_EN
    output logic [15:0]                   run_count,
`endif
    output logic                          run_mode
);

    localparam int DW = pixel_length + 1;

    // Thresholds in the same signed width as the differences.
    localparam logic signed [DW-1:0] c_t1    = DW'(T1);
    localparam logic signed [DW-1:0] c_t2    = DW'(T2);
    localparam logic signed [DW-1:0] c_t3    = DW'(T3);
    localparam logic signed [DW-1:0] c_near  = DW'(NEAR);
    localparam logic signed [DW-1:0] c_nt1   = -c_t1;
    localparam logic signed [DW-1:0] c_nt2   = -c_t2;
    localparam logic signed [DW-1:0] c_nt3   = -c_t3;
    localparam logic signed [DW-1:0] c_nnear = -c_near;

    localparam logic signed [Q_length-1:0] c_q0 = '0;
    localparam logic signed [Q_length-1:0] c_q1 = Q_length'(1);
    localparam logic signed [Q_length-1:0] c_q2 = Q_length'(2);
    localparam logic signed [Q_length-1:0] c_q3 = Q_length'(3);
    localparam logic signed [Q_length-1:0] c_q4 = Q_length'(4);

    localparam logic signed [CTX_length-1:0] c_k81 = CTX_length'(81);
    localparam logic signed [CTX_length-1:0] c_k9  = CTX_length'(9);

    function automatic logic signed [Q_length-1:0] f_quant(input logic signed [DW-1:0] di);
        if (di <= c_nt3)         return -c_q4;
        else if (di <= c_nt2)    return -c_q3;
        else if (di <= c_nt1)    return -c_q2;
        else if (di < c_nnear)   return -c_q1;
        else if (di <= c_near)   return c_q0;
        else if (di < c_t1)      return c_q1;
        else if (di < c_t2)      return c_q2;
        else if (di < c_t3)      return c_q3;
        else                     return c_q4;
    endfunction

    // One enable drives both stages so a stall freezes the whole pipe.
    logic w_en;
    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    // ---------------- Stage 1: gradients ----------------
    logic                 r_s1_valid;
    logic signed [DW-1:0] r_d1, r_d2, r_d3;
    logic signed [DW-1:0] w_d1, w_d2, w_d3;

    // Zero-extended operands: the full -2^P+1..2^P-1 range fits, no wrap.
    assign w_d1 = $signed({1'b0, d}) - $signed({1'b0, b});
    assign w_d2 = $signed({1'b0, b}) - $signed({1'b0, c});
    assign w_d3 = $signed({1'b0, c}) - $signed({1'b0, a});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_d3       <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            // Data only loads with a valid item so idle cycles do not toggle it.
            if (in_valid) begin
                r_d1 <= w_d1;
                r_d2 <= w_d2;
                r_d3 <= w_d3;
            end
        end
    end

    // ---------------- Stage 2: quantize, merge, context ----------------
    logic signed [Q_length-1:0]   w_q1, w_q2, w_q3;
    logic signed [Q_length-1:0]   w_m1, w_m2, w_m3;
    logic signed [CTX_length-1:0] w_x1, w_x2, w_x3, w_ctx;
    logic                         w_neg, w_run;

    assign w_q1 = f_quant(r_d1);
    assign w_q2 = f_quant(r_d2);
    assign w_q3 = f_quant(r_d3);

    // Negative if the first nonzero component is negative.
    assign w_neg = (w_q1 < 0) ||
                   ((w_q1 == 0) && (w_q2 < 0)) ||
                   ((w_q1 == 0) && (w_q2 == 0) && (w_q3 < 0));
    assign w_run = (w_q1 == 0) && (w_q2 == 0) && (w_q3 == 0);

    assign w_m1 = w_neg ? -w_q1 : w_q1;
    assign w_m2 = w_neg ? -w_q2 : w_q2;
    assign w_m3 = w_neg ? -w_q3 : w_q3;

    // After merging the index is always 0..364, so modulo-2^CTX_length
    // two's-complement arithmetic yields the exact value.
    assign w_x1  = CTX_length'(w_m1);
    assign w_x2  = CTX_length'(w_m2);
    assign w_x3  = CTX_length'(w_m3);
    assign w_ctx = c_k81 * w_x1 + c_k9 * w_x2 + w_x3;

    logic                         r_out_valid;
    logic signed [Q_length-1:0]   r_q1, r_q2, r_q3;
    logic                         r_sign, r_run;
    logic [CTX_length-1:0]        r_ctx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_q1        <= '0;
            r_q2        <= '0;
            r_q3        <= '0;
            r_sign      <= 1'b0;
            r_ctx       <= '0;
            r_run       <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_q1   <= w_m1;
                r_q2   <= w_m2;
                r_q3   <= w_m3;
                r_sign <= w_neg;
                r_ctx  <= $unsigned(w_ctx);
                r_run  <= w_run;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Q_1       = r_q1;
    assign Q_2       = r_q2;
    assign Q_3       = r_q3;
    assign sign      = r_sign;
    assign ctx       = r_ctx;
    assign run_mode  = r_run;

`ifdef GRAD_RUN_COUNT_EN
    logic [15:0] r_run_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_count <= '0;
        end else if (r_out_valid && out_ready && r_run && (r_run_count != 16'hFFFF)) begin
            r_run_count <= r_run_count + 16'd1;
        end
    end

    assign run_count = r_run_count;
`else
    // Run-mode counter not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_gradient_context_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_gradient_context_pipe
// Purpose  : Directed self-checking bench for gradient_context_pipe: reset
//            state, latency, quantizer thresholds, sign merge, extremes,
//            backpressure ordering/hold and reset with items in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gradient_context_pipe;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        a, b, c, d;
    logic              out_valid;
    logic              out_ready;
    logic signed [3:0] Q_1, Q_2, Q_3;
    logic              sign;
    logic [8:0]        ctx;
    logic              run_mode;
`ifdef GRAD_RUN_COUNT_EN
    logic [15:0]       run_count;
`endif

    int checks   = 0;
    int failures = 0;

    gradient_context_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q_1       (Q_1),
        .Q_2       (Q_2),
        .Q_3       (Q_3),
        .sign      (sign),
        .ctx       (ctx),
`ifdef GRAD_RUN_COUNT_EN
        .run_count (run_count),
`endif
        .run_mode  (run_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] ia, ib, ic, id);
        in_valid = v;
        a = ia;
        b = ib;
        c = ic;
        d = id;
    endtask

    task automatic chk_out(input string tag, input int q1, q2, q3, s, cx, rm);
        chk({tag, ".Q_1"},      Q_1,      q1);
        chk({tag, ".Q_2"},      Q_2,      q2);
        chk({tag, ".Q_3"},      Q_3,      q3);
        chk({tag, ".sign"},     sign,     s);
        chk({tag, ".ctx"},      ctx,      cx);
        chk({tag, ".run_mode"}, run_mode, rm);
    endtask

    // Single item with out_ready high: result appears two edges after acceptance.
    task automatic run_vec(input string tag, input logic [7:0] ia, ib, ic, id,
                           input int q1, q2, q3, s, cx, rm);
        set_in(1'b1, ia, ib, ic, id);
        tick();
        set_in(1'b0, ia, ib, ic, id);
        chk({tag, ".lat1"}, out_valid, 0);
        tick();
        chk({tag, ".out_valid"}, out_valid, 1);
        chk_out(tag, q1, q2, q3, s, cx, rm);
    endtask

    // Stream vectors and expected results
    logic [7:0] va[4]   = '{8'd100, 8'd10, 8'd15, 8'd255};
    logic [7:0] vb[4]   = '{8'd100, 8'd20, 8'd15, 8'd0};
    logic [7:0] vc[4]   = '{8'd100, 8'd15, 8'd20, 8'd0};
    logic [7:0] vd[4]   = '{8'd100, 8'd40, 8'd0,  8'd255};
    int         e_q1[4] = '{0, 3, 3, 4};
    int         e_q3[4] = '{0, 2, -2, -4};
    int         e_s[4]  = '{0, 0, 1, 0};
    int         e_cx[4] = '{0, 263, 259, 320};
    int         e_rm[4] = '{1, 0, 0, 0};

    initial begin
        int   in_i;
        int   out_i;
        int   stall_left;
        bit   started;
        bit   acc_in;
        logic [8:0] snap_ctx;
        logic       snap_sign;
        logic signed [3:0] snap_q3;

        // ---- reset ----
        reset     = 1'b1;
        out_ready = 1'b1;
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst.out_valid", out_valid, 0);
        chk_out("rst", 0, 0, 0, 0, 0, 0);
        chk("rst.in_ready", in_ready, 1);
`ifdef GRAD_RUN_COUNT_EN
        chk("rst.run_count", run_count, 0);
`endif

        // ---- directed vectors ----
        run_vec("flat",   8'd100, 8'd100, 8'd100, 8'd100, 0, 0, 0, 0, 0, 1);
        run_vec("pos",    8'd10,  8'd20,  8'd15,  8'd40,  3, 2, 2, 0, 263, 0);
        run_vec("merge",  8'd15,  8'd15,  8'd20,  8'd0,   3, 2, -2, 1, 259, 0);
        run_vec("ext",    8'd255, 8'd0,   8'd0,   8'd255, 4, 0, -4, 0, 320, 0);
        // Threshold edges on D1 with b=c=a so D2=D3=0
        run_vec("d1p2",   8'd50, 8'd50, 8'd50, 8'd52, 1, 0, 0, 0, 81, 0);
        run_vec("d1p3",   8'd50, 8'd50, 8'd50, 8'd53, 2, 0, 0, 0, 162, 0);
        run_vec("d1m1",   8'd50, 8'd50, 8'd50, 8'd49, 1, 0, 0, 1, 81, 0);
        run_vec("d1m7",   8'd50, 8'd50, 8'd50, 8'd43, 3, 0, 0, 1, 243, 0);
        run_vec("d1p21",  8'd50, 8'd50, 8'd50, 8'd71, 4, 0, 0, 0, 324, 0);
        run_vec("d1m21",  8'd50, 8'd50, 8'd50, 8'd29, 4, 0, 0, 1, 324, 0);
        tick();
        chk("idle.out_valid", out_valid, 0);

        // ---- backpressure stream ----
        in_i       = 0;
        out_i      = 0;
        stall_left = 0;
        started    = 1'b0;
        snap_ctx   = '0;
        snap_sign  = 1'b0;
        snap_q3    = '0;
        for (int cyc = 0; cyc < 40 && out_i < 4; cyc++) begin
            if (!started && out_valid) begin
                started    = 1'b1;
                stall_left = 5;
                snap_ctx   = ctx;
                snap_sign  = sign;
                snap_q3    = Q_3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (in_i < 4) set_in(1'b1, va[in_i], vb[in_i], vc[in_i], vd[in_i]);
            else          set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
            #1;
            if (out_valid && !out_ready) begin
                chk("bp.in_ready",  in_ready, 0);
                chk("bp.hold_ctx",  ctx,      snap_ctx);
                chk("bp.hold_sign", sign,     snap_sign);
                chk("bp.hold_q3",   Q_3,      snap_q3);
            end
            acc_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bp.q1",   Q_1,      e_q1[out_i]);
                chk("bp.q3",   Q_3,      e_q3[out_i]);
                chk("bp.sign", sign,     e_s[out_i]);
                chk("bp.ctx",  ctx,      e_cx[out_i]);
                chk("bp.run",  run_mode, e_rm[out_i]);
                out_i++;
            end
            tick();
            if (acc_in) in_i++;
        end
        chk("bp.delivered", out_i, 4);
        chk("bp.accepted",  in_i,  4);
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        chk("bp.nodup0", out_valid, 0);
        tick();
        chk("bp.nodup1", out_valid, 0);
`ifdef GRAD_RUN_COUNT_EN
        chk("cnt.run_count", run_count, 2);
`endif

        // ---- reset with two items in flight ----
        out_ready = 1'b0;
        set_in(1'b1, 8'd10, 8'd20, 8'd15, 8'd40);
        tick();
        set_in(1'b1, 8'd15, 8'd15, 8'd20, 8'd0);
        tick();
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("mr.out_valid", out_valid, 1);
        chk("mr.ctx",       ctx,       263);
        chk("mr.in_ready",  in_ready,  0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("mr.cleared_valid", out_valid, 0);
        chk_out("mr.cleared", 0, 0, 0, 0, 0, 0);
`ifdef GRAD_RUN_COUNT_EN
        chk("mr.run_count", run_count, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr.nothing_emerges", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
